object_draw_pipeline: RTL and testbench

Consumes the packed object-state vector produced by a state controller (img_id, x, y, width, height) and renders that object into the VGA pixel stream. Latches the state once per frame, tests every scanned pixel against the object rectangle, fetches a tiled 32×32 texel from the bitmap ROM, and drives a draw request plus RGB332 colour to the priority mux. Sits between the object/background controllers and the VGA compositor.

---
 rtl/object_draw_pipeline_pkg.sv | 17 +
 rtl/object_draw_pipeline_bitmap_rom.sv | 10 +
 rtl/object_draw_pipeline.sv | 52 +++++
 tb/tb_object_draw_pipeline.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/object_draw_pipeline_pkg.sv
// object_draw_pipeline_pkg: shared field layout, widths and bitmap image for the object draw path.
package obj_pkg;
  localparam int IMG_ID = 0;
  localparam int X = 1;
  localparam int Y = 2;
  localparam int WIDTH = 3;
  localparam int HEIGHT = 4;
  localparam int FIELD_W = 11;
  localparam int TILE_BITS = 5;
  localparam int ROM_ADDR_W = 15;
  localparam logic [7:0] TRANSPARENT = 8'hFF;
  typedef logic [0:4][0:FIELD_W-1] object_state_t;
  // Bitmap image: addr = {img, ty, tx}; one transparent hole in image 3 at (tx=7, ty=5).
  function automatic logic [7:0] rom_texel(input logic [ROM_ADDR_W-1:0] a);
    return (a == {5'd3, 5'd5, 5'd7}) ? TRANSPARENT : {1'b0, a[11:10], a[9:5] ^ a[4:0]};
  endfunction
endpackage

// File: rtl/object_draw_pipeline_bitmap_rom.sv
// object_bitmap_rom: 32Kx8 synchronous-read bitmap ROM, one cycle of read latency.
module object_bitmap_rom
  import obj_pkg::*;
(
  input  logic                  clk,
  input  logic [ROM_ADDR_W-1:0] i_addr,
  output logic [7:0]            o_data
);
  always_ff @(posedge clk) o_data <= rom_texel(i_addr);
endmodule

// File: rtl/object_draw_pipeline.sv
// object_draw_pipeline: per-frame latched object rectangle test, tiled texel fetch, RGB332 draw request.
module object_draw_pipeline
  import obj_pkg::*;
(
  input  logic          clk,
  input  logic          resetN,
  input  logic          frame_start,
  input  object_state_t object_state,
  input  logic [10:0]   pixelX,
  input  logic [10:0]   pixelY,
  output logic          drawingRequest,
  output logic [7:0]    RGBout
);
  object_state_t         r_shadow;
  logic [FIELD_W-1:0]    w_img, w_x, w_y, w_w, w_h;
  logic [FIELD_W:0]      w_dx, w_dy;
  logic                  w_hit, r_hit, r_hit_d;
  logic [ROM_ADDR_W-1:0] r_addr;
  logic [7:0]            w_texel;
  assign w_img = r_shadow[IMG_ID];
  assign w_x   = r_shadow[X];
  assign w_y   = r_shadow[Y];
  assign w_w   = r_shadow[WIDTH];
  assign w_h   = r_shadow[HEIGHT];
  // Offsets wrap mod 2^12; bit 11 set means the pixel lies left of / above the object.
  assign w_dx  = {1'b0, pixelX} - {w_x[FIELD_W-1], w_x};
  assign w_dy  = {1'b0, pixelY} - {w_y[FIELD_W-1], w_y};
  assign w_hit = (w_img[FIELD_W-1:TILE_BITS] == '0) && !w_dx[FIELD_W] && !w_dy[FIELD_W] &&
                 (w_dx[FIELD_W-1:0] < w_w) && (w_dy[FIELD_W-1:0] < w_h);
  object_bitmap_rom u_rom (
    .clk    (clk),
    .i_addr (r_addr),
    .o_data (w_texel)
  );
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_shadow       <= '0;
      r_hit          <= 1'b0;
      r_addr         <= '0;
      r_hit_d        <= 1'b0;
      drawingRequest <= 1'b0;
      RGBout         <= 8'h00;
    end else begin
      if (frame_start) r_shadow <= object_state;
      r_hit          <= w_hit;
      r_addr         <= {w_img[TILE_BITS-1:0], w_dy[TILE_BITS-1:0], w_dx[TILE_BITS-1:0]};
      r_hit_d        <= r_hit;
      drawingRequest <= r_hit_d && (w_texel != TRANSPARENT);
      RGBout         <= (r_hit_d && (w_texel != TRANSPARENT)) ? w_texel : 8'h00;
    end
  end
endmodule

// File: tb/tb_object_draw_pipeline.sv
// tb_object_draw_pipeline: directed pixel stream with a 3-deep expectation pipe checked every cycle.
module tb_object_draw_pipeline;
  import obj_pkg::*;
  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          frame_start = 1'b0;
  object_state_t object_state = '0;
  logic [10:0]   pixelX = '0;
  logic [10:0]   pixelY = '0;
  logic          drawingRequest;
  logic [7:0]    RGBout;
  int            n_assert = 0;
  int            n_fail = 0;
  logic          p_v [3];
  logic          p_dr [3];
  logic [7:0]    p_rgb [3];
  string         p_tag [3];
  object_state_t st_a, st_b, st_n, st_dis, st_w0, st_h0;

  object_draw_pipeline dut (
    .clk            (clk),
    .resetN         (resetN),
    .frame_start    (frame_start),
    .object_state   (object_state),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .drawingRequest (drawingRequest),
    .RGBout         (RGBout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic edr, input logic [7:0] ergb);
    n_assert++;
    assert (drawingRequest === edr) else begin
      n_fail++;
      $error("FAIL %s drawingRequest observed=%b expected=%b", tag, drawingRequest, edr);
    end
    n_assert++;
    assert (RGBout === ergb) else begin
      n_fail++;
      $error("FAIL %s RGBout observed=%h expected=%h", tag, RGBout, ergb);
    end
  endtask

  // Drives one pixel, advances one clock, then checks the pixel driven two calls earlier.
  task automatic cyc(input logic [10:0] x, input logic [10:0] y, input logic fs,
                     input logic v, input logic edr, input logic [7:0] ergb, input string tag);
    pixelX = x;
    pixelY = y;
    frame_start = fs;
    for (int i = 2; i > 0; i--) begin
      p_v[i] = p_v[i-1];
      p_dr[i] = p_dr[i-1];
      p_rgb[i] = p_rgb[i-1];
      p_tag[i] = p_tag[i-1];
    end
    p_v[0] = v;
    p_dr[0] = edr;
    p_rgb[0] = ergb;
    p_tag[0] = tag;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    if (p_v[2]) chk(p_tag[2], p_dr[2], p_rgb[2]);
  endtask

  task automatic flush();
    cyc(11'h7FF, 11'h7FF, 1'b0, 1'b0, 1'b0, 8'h00, "idle");
    cyc(11'h7FF, 11'h7FF, 1'b0, 1'b0, 1'b0, 8'h00, "idle");
  endtask

  task automatic latch(input object_state_t s);
    object_state = s;
    cyc(11'h7FF, 11'h7FF, 1'b1, 1'b0, 1'b0, 8'h00, "latch");
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      p_v[i] = 1'b0;
      p_dr[i] = 1'b0;
      p_rgb[i] = 8'h00;
      p_tag[i] = "";
    end
    st_a = '0;
    st_a[IMG_ID] = 11'd3; st_a[X] = 11'd100; st_a[Y] = 11'd50; st_a[WIDTH] = 11'd64; st_a[HEIGHT] = 11'd32;
    st_b = st_a;
    st_b[X] = 11'd101;
    st_n = '0;
    st_n[IMG_ID] = 11'd3; st_n[X] = 11'd0; st_n[Y] = 11'h7FF; st_n[WIDTH] = 11'd64; st_n[HEIGHT] = 11'd32;
    st_dis = st_a;
    st_dis[IMG_ID] = 11'h020;
    st_w0 = st_a;
    st_w0[WIDTH] = 11'd0;
    st_h0 = st_a;
    st_h0[HEIGHT] = 11'd0;

    @(posedge clk);
    #1;
    chk("reset", 1'b0, 8'h00);
    object_state = st_a;
    @(posedge clk);
    #1;
    resetN = 1'b1;
    cyc(11'd110, 11'd60, 1'b0, 1'b1, 1'b0, 8'h00, "pre_frame");
    flush();

    latch(st_a);
    for (int x = 99; x <= 164; x++) begin
      logic [10:0] px;
      logic [4:0]  tx;
      px = 11'(x);
      tx = 5'(x - 100);
      if (x >= 100 && x <= 163) cyc(px, 11'd50, 1'b0, 1'b1, 1'b1, {3'b011, tx}, "sweep");
      else cyc(px, 11'd50, 1'b0, 1'b1, 1'b0, 8'h00, "sweep_edge");
    end
    flush();

    object_state = st_b;
    cyc(11'd100, 11'd50, 1'b0, 1'b1, 1'b1, 8'h60, "no_latch");
    cyc(11'd100, 11'd50, 1'b1, 1'b1, 1'b1, 8'h60, "old_on_fs");
    cyc(11'd100, 11'd50, 1'b0, 1'b1, 1'b0, 8'h00, "new_after_fs");
    cyc(11'd101, 11'd50, 1'b0, 1'b1, 1'b1, 8'h60, "new_origin");
    flush();

    latch(st_a);
    cyc(11'd106, 11'd55, 1'b0, 1'b1, 1'b1, 8'h63, "opaque_left");
    cyc(11'd107, 11'd55, 1'b0, 1'b1, 1'b0, 8'h00, "transparent");
    cyc(11'd108, 11'd55, 1'b0, 1'b1, 1'b1, 8'h6D, "opaque_right");
    flush();

    latch(st_n);
    cyc(11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 8'h61, "neg_y_row0");
    cyc(11'd0, 11'd30, 1'b0, 1'b1, 1'b1, 8'h7F, "neg_y_row30");
    cyc(11'd0, 11'd31, 1'b0, 1'b1, 1'b0, 8'h00, "neg_y_row31");
    flush();

    latch(st_dis);
    cyc(11'd110, 11'd60, 1'b0, 1'b1, 1'b0, 8'h00, "img_disabled");
    cyc(11'd100, 11'd50, 1'b0, 1'b1, 1'b0, 8'h00, "img_disabled_org");
    latch(st_w0);
    cyc(11'd100, 11'd50, 1'b0, 1'b1, 1'b0, 8'h00, "width0");
    latch(st_h0);
    cyc(11'd100, 11'd50, 1'b0, 1'b1, 1'b0, 8'h00, "height0");
    flush();

    latch(st_a);
    cyc(11'd100, 11'd50, 1'b0, 1'b1, 1'b1, 8'h60, "pre_rst0");
    cyc(11'd101, 11'd50, 1'b0, 1'b1, 1'b1, 8'h61, "pre_rst1");
    cyc(11'd102, 11'd50, 1'b0, 1'b0, 1'b0, 8'h00, "pre_rst2");
    resetN = 1'b0;
    #1;
    chk("async_reset", 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) p_v[i] = 1'b0;
    #1;
    resetN = 1'b1;
    for (int x = 103; x < 109; x++) cyc(11'(x), 11'd50, 1'b0, 1'b1, 1'b0, 8'h00, "post_reset");
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
